mult_div_unit: RTL and testbench

//  EX-stage multiply/divide unit with architectural HI/LO registers. Consumes the decoder's

---
 rtl/mult_div_unit_pkg.sv | 25 ++
 rtl/mult_div_unit_md_arith.sv | 51 +++++
 rtl/mult_div_unit.sv | 104 ++++++++++
 tb/tb_mult_div_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;

  localparam logic MD_IDLE = 1'b0;
  localparam logic MD_RUN  = 1'b1;

  typedef enum logic {
    MdIdle = MD_IDLE,
    MdRun  = MD_RUN
  } md_state_e;

  function automatic logic md_op_valid(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational 32x32 multiply/divide datapath; result is {hi,lo} as MIPS defines them.
module md_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor, uq, ur, quo, rem;

  // Sign-extending to 64 bits makes the truncated unsigned product equal the signed one.
  assign mul_a = (op == MD_MULT) ? {{32{a[31]}}, a} : {32'b0, a};
  assign mul_b = (op == MD_MULT) ? {{32{b[31]}}, b} : {32'b0, b};
  assign prod  = mul_a * mul_b;

  // Signed divide via magnitudes; quotient truncates toward zero, remainder follows dividend.
  assign a_neg   = (op == MD_DIV) && a[31];
  assign b_neg   = (op == MD_DIV) && b[31];
  assign a_mag   = a_neg ? (32'd0 - a) : a;
  assign b_mag   = b_neg ? (32'd0 - b) : b;
  assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq      = a_mag / divisor;
  assign ur      = a_mag % divisor;
  assign quo     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem     = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_hi   = rem;
        res_lo   = quo;
        div_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: HI/LO registers plus a counter modelling mult/div latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rhi_q, rhi_d, rlo_q, rlo_d;
  logic            rdz_q, rdz_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic [31:0] res_hi, res_lo;
  logic        div_zero;

  md_arith u_md_arith (
    .op       (op),
    .a        (a),
    .b        (b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rhi_d   = rhi_q;
    rlo_d   = rlo_q;
    rdz_d   = rdz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MdIdle: begin
        if (!req) begin
          if (start && md_op_valid(op)) begin
            state_d = MdRun;
            rhi_d   = res_hi;
            rlo_d   = res_lo;
            rdz_d   = div_zero;
            cnt_d   = md_op_is_div(op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          end
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end
      MdRun: begin
        // Already retired past EX, so req does not cancel an op in flight.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = MdIdle;
          if (!rdz_q) begin
            hi_d = rhi_q;
            lo_d = rlo_q;
          end
        end
      end
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MdIdle;
      cnt_q   <= '0;
      rhi_q   <= 32'd0;
      rlo_q   <= 32'd0;
      rdz_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      rdz_q   <= rdz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MdRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/latency queued at issue, checked at completion.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        req = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic [31:0] cur_hi, cur_lo;

  mult_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .req   (req),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Stall logic guarantees no issue while busy; the bench must never do it.
  always @(negedge clk) begin
    if (busy && (start || mthi || mtlo)) begin
      $display("FAIL issue_while_busy: start=%0b mthi=%0b mtlo=%0b required none", start, mthi,
               mtlo);
      bad++;
    end
  end

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    int sx, sy, q, r;
    longint p;
    logic [63:0] u;
    sx = x;
    sy = y;
    h = 32'd0;
    l = 32'd0;
    case (o)
      MD_MULT:  begin p = longint'(sx) * longint'(sy); {h, l} = p; end
      MD_MULTU: begin u = {32'd0, x} * {32'd0, y}; {h, l} = u; end
      MD_DIV:   begin q = sx / sy; r = sx % sy; l = q; h = r; end
      MD_DIVU:  begin l = x / y; h = x % y; end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] eh, input logic [31:0] el, input int n,
                       input string nm);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.cycles = n;
    e.name = nm;
    sb.push_back(e);
    start = 1'b1;
    op = o;
    a = xa;
    b = xb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    total += 3;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %0b want 0", busy); bad++; end
    if (hi !== 32'd0) begin $display("FAIL reset_hi: got %h want 0", hi); bad++; end
    if (lo !== 32'd0) begin $display("FAIL reset_lo: got %h want 0", lo); bad++; end
  endtask

  // Spec vectors for mult/multu/div including the signed-overflow divide.
  task automatic test_vectors;
    logic [2:0]  ops[4] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIV};
    logic [31:0] as[4]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] bs[4]  = '{32'd3, 32'd2, 32'd2, 32'hFFFFFFFF};
    logic [31:0] ehs[4] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] els[4] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h80000000};
    int          ns[4]  = '{5, 5, 10, 10};
    int          n;
    exp_t        e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], ehs[i], els[i], ns[i], $sformatf("vec%0d", i));
      wait_idle(n);
      e = sb.pop_front();
      total += 3;
      if (n !== e.cycles) begin $display("FAIL %s_busy: got %0d want %0d", e.name, n, e.cycles); bad++; end
      if (hi !== e.hi) begin $display("FAIL %s_hi: got %h want %h", e.name, hi, e.hi); bad++; end
      if (lo !== e.lo) begin $display("FAIL %s_lo: got %h want %h", e.name, lo, e.lo); bad++; end
    end
    cur_hi = hi;
    cur_lo = lo;
  endtask

  task automatic test_div_zero;
    int   n;
    exp_t e;
    mthi = 1'b1;
    mtlo = 1'b1;
    a = 32'h12345678;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    total += 2;
    if (hi !== 32'h12345678) begin $display("FAIL mt_both_hi: got %h want 12345678", hi); bad++; end
    if (lo !== 32'h12345678) begin $display("FAIL mt_both_lo: got %h want 12345678", lo); bad++; end
    issue(MD_DIVU, 32'd7, 32'd0, 32'h12345678, 32'h12345678, 10, "divzero");
    wait_idle(n);
    e = sb.pop_front();
    total += 3;
    if (n !== e.cycles) begin $display("FAIL %s_busy: got %0d want %0d", e.name, n, e.cycles); bad++; end
    if (hi !== e.hi) begin $display("FAIL %s_hi: got %h want %h", e.name, hi, e.hi); bad++; end
    if (lo !== e.lo) begin $display("FAIL %s_lo: got %h want %h", e.name, lo, e.lo); bad++; end
    cur_hi = 32'h12345678;
    cur_lo = 32'h12345678;
  endtask

  task automatic test_req;
    start = 1'b1;
    op = MD_MULT;
    a = 32'hAA;
    b = 32'd3;
    mthi = 1'b1;
    mtlo = 1'b1;
    req = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    req = 1'b0;
    total += 3;
    if (busy !== 1'b0) begin $display("FAIL req_busy: got %0b want 0", busy); bad++; end
    if (hi !== cur_hi) begin $display("FAIL req_hi: got %h want %h", hi, cur_hi); bad++; end
    if (lo !== cur_lo) begin $display("FAIL req_lo: got %h want %h", lo, cur_lo); bad++; end
    mthi = 1'b1;
    a = 32'hAA;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    total += 3;
    if (hi !== 32'hAA) begin $display("FAIL mthi_hi: got %h want 000000aa", hi); bad++; end
    if (lo !== cur_lo) begin $display("FAIL mthi_lo: got %h want %h", lo, cur_lo); bad++; end
    if (busy !== 1'b0) begin $display("FAIL mthi_busy: got %0b want 0", busy); bad++; end
    mtlo = 1'b1;
    a = 32'h55;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    total += 2;
    if (lo !== 32'h55) begin $display("FAIL mtlo_lo: got %h want 00000055", lo); bad++; end
    if (hi !== 32'hAA) begin $display("FAIL mtlo_hi: got %h want 000000aa", hi); bad++; end
    cur_hi = 32'hAA;
    cur_lo = 32'h55;
  endtask

  task automatic test_req_during_run;
    int   n;
    exp_t e;
    issue(MD_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5, "req_in_run");
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle(n);
    n++;
    e = sb.pop_front();
    total += 3;
    if (n !== e.cycles) begin $display("FAIL %s_busy: got %0d want %0d", e.name, n, e.cycles); bad++; end
    if (hi !== e.hi) begin $display("FAIL %s_hi: got %h want %h", e.name, hi, e.hi); bad++; end
    if (lo !== e.lo) begin $display("FAIL %s_lo: got %h want %h", e.name, lo, e.lo); bad++; end
    cur_hi = hi;
    cur_lo = lo;
  endtask

  task automatic test_bad_op;
    logic [2:0] bad_ops[3] = '{3'd0, 3'd5, 3'd7};
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      op = bad_ops[i];
      a = 32'd9;
      b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      total += 2;
      if (busy !== 1'b0) begin $display("FAIL badop%0d_busy: got %0b want 0", i, busy); bad++; end
      if (lo !== cur_lo) begin $display("FAIL badop%0d_lo: got %h want %h", i, lo, cur_lo); bad++; end
    end
  endtask

  // Back-to-back random ops: next issue lands on the cycle busy falls.
  task automatic test_back_to_back;
    logic [2:0]  o;
    logic [31:0] x, y, eh, el;
    int          n;
    exp_t        e;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(1, 4));
      x = $urandom;
      y = $urandom;
      if (i < 2) y = y & 32'hF;
      if (y == 32'd0) y = 32'd5;
      if (o == MD_DIV && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd3;
      model(o, x, y, eh, el);
      issue(o, x, y, eh, el, md_op_is_div(o) ? 10 : 5, $sformatf("rnd%0d_op%0d", i, o));
      wait_idle(n);
      e = sb.pop_front();
      total += 3;
      if (n !== e.cycles) begin $display("FAIL %s_busy: got %0d want %0d", e.name, n, e.cycles); bad++; end
      if (hi !== e.hi) begin $display("FAIL %s_hi: got %h want %h", e.name, hi, e.hi); bad++; end
      if (lo !== e.lo) begin $display("FAIL %s_lo: got %h want %h", e.name, lo, e.lo); bad++; end
    end
  endtask

  task automatic test_reset_mid_div;
    int   n;
    exp_t e;
    start = 1'b1;
    op = MD_DIV;
    a = 32'd100;
    b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (busy !== 1'b0) begin $display("FAIL async_rst_busy: got %0b want 0", busy); bad++; end
    if (hi !== 32'd0) begin $display("FAIL async_rst_hi: got %h want 0", hi); bad++; end
    if (lo !== 32'd0) begin $display("FAIL async_rst_lo: got %h want 0", lo); bad++; end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(MD_MULT, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 5, "post_rst_mult");
    wait_idle(n);
    e = sb.pop_front();
    total += 3;
    if (n !== e.cycles) begin $display("FAIL %s_busy: got %0d want %0d", e.name, n, e.cycles); bad++; end
    if (hi !== e.hi) begin $display("FAIL %s_hi: got %h want %h", e.name, hi, e.hi); bad++; end
    if (lo !== e.lo) begin $display("FAIL %s_lo: got %h want %h", e.name, lo, e.lo); bad++; end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset;
    test_vectors;
    test_div_zero;
    test_req;
    test_req_during_run;
    test_bad_op;
    test_back_to_back;
    test_reset_mid_div;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
